// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU: PC-select codes, opcodes,
// the bubble word and the fetch FSM state type.
package cpu_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;
    localparam int CNT_W   = 16;

    // PC-select codes produced by the control unit (mux1)
    typedef enum logic [1:0] {
        PCSEL_HALT   = 2'b00,
        PCSEL_SEQ    = 2'b01,
        PCSEL_JUMP   = 2'b10,
        PCSEL_BRANCH = 2'b11
    } pc_sel_e;

    localparam logic [3:0] OP_HALT = 4'b1111;
    localparam logic [3:0] OP_JUMP = 4'b1100;

    // Opcode 0000 / func 0000: no register write, no memory access, no branch
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_next.sv
// Combinational next-PC selection for the fetch stage: sequential step,
// PC-relative jump, taken branch, or hold (stall / halt / frozen).
module fetch_pc_next
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH = 16
) (
    input  logic [1:0]          pc_sel_i,
    input  logic                stall_i,
    input  logic                run_i,
    input  logic [PC_WIDTH-1:0] pc_i,
    input  logic [PC_WIDTH-1:0] pc_id_i,
    input  logic [11:0]         jump_imm_i,
    input  logic [PC_WIDTH-1:0] branch_target_i,
    output logic [PC_WIDTH-1:0] pc_next_o
);

    logic [PC_WIDTH-1:0] jump_offset;
    logic [PC_WIDTH-1:0] jump_target;
    logic [PC_WIDTH-1:0] seq_target;
    logic [PC_WIDTH-1:0] branch_even;
    pc_sel_e             sel;

    // Jump offset is a signed 12-bit word count, converted to a byte offset.
    // The jump is relative to the address of the jump instruction itself,
    // which is the one currently sitting in IF/ID.
    assign jump_offset = {{(PC_WIDTH-13){jump_imm_i[11]}}, jump_imm_i, 1'b0};
    assign jump_target = pc_id_i + jump_offset;
    assign seq_target  = pc_i + PC_WIDTH'(2);
    // Instructions are halfword aligned, so the PC is kept even.
    assign branch_even = {branch_target_i[PC_WIDTH-1:1], 1'b0};
    assign sel         = pc_sel_e'(pc_sel_i);

    // Redirects beat a stall: the stalled word is on the wrong path anyway.
    always_comb begin
        pc_next_o = pc_i;
        if (run_i) begin
            unique case (sel)
                PCSEL_HALT:   pc_next_o = pc_i;
                PCSEL_JUMP:   pc_next_o = jump_target;
                PCSEL_BRANCH: pc_next_o = branch_even;
                PCSEL_SEQ:    pc_next_o = stall_i ? pc_i : seq_target;
                default:      pc_next_o = pc_i;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID pipeline buffer. Owns the PC, presents it
// to instruction memory, captures the returned word one cycle later, squashes
// wrong-path fetches on redirects and freezes permanently on halt.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                    PC_WIDTH    = 16,
    parameter int                    INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = 16'h0000,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR  = 16'h0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             pc_sel,
    input  logic                   stall,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr_id,
    output logic [PC_WIDTH-1:0]    pc_id,
    output logic                   valid_id,
    output logic                   halted,
    output logic [CNT_W-1:0]       fetch_count
);

    fetch_state_e           state_q,       state_d;
    logic [PC_WIDTH-1:0]    pc_q,          pc_d;
    logic [INSTR_WIDTH-1:0] instr_id_q,    instr_id_d;
    logic [PC_WIDTH-1:0]    pc_id_q,       pc_id_d;
    logic                   valid_id_q,    valid_id_d;
    logic [CNT_W-1:0]       fetch_count_q, fetch_count_d;

    pc_sel_e sel;
    logic    run;

    assign sel = pc_sel_e'(pc_sel);
    assign run = (state_q == ST_RUN);

    fetch_pc_next #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc_next (
        .pc_sel_i        (pc_sel),
        .stall_i         (stall),
        .run_i           (run),
        .pc_i            (pc_q),
        .pc_id_i         (pc_id_q),
        .jump_imm_i      (instr_id_q[11:0]),
        .branch_target_i (branch_target),
        .pc_next_o       (pc_d)
    );

    // FSM next state and IF/ID buffer / fetch counter updates
    always_comb begin
        state_d       = state_q;
        instr_id_d    = instr_id_q;
        pc_id_d       = pc_id_q;
        valid_id_d    = valid_id_q;
        fetch_count_d = fetch_count_q;
        unique case (state_q)
            ST_RUN: begin
                unique case (sel)
                    PCSEL_HALT: begin
                        state_d    = ST_HALT;
                        instr_id_d = NOP_INSTR;
                        valid_id_d = 1'b0;
                    end
                    PCSEL_JUMP, PCSEL_BRANCH: begin
                        instr_id_d = NOP_INSTR;
                        valid_id_d = 1'b0;
                    end
                    PCSEL_SEQ: begin
                        if (!stall) begin
                            instr_id_d = imem_rdata;
                            pc_id_d    = pc_q;
                            valid_id_d = 1'b1;
                            if (fetch_count_q != {CNT_W{1'b1}}) begin
                                fetch_count_d = fetch_count_q + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
            ST_HALT: begin
                // Only reset leaves HALT; everything stays frozen.
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // State registers with immediate (asynchronous) reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            instr_id_q    <= NOP_INSTR;
            pc_id_q       <= '0;
            valid_id_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_id_q    <= instr_id_d;
            pc_id_q       <= pc_id_d;
            valid_id_q    <= valid_id_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr_id    = instr_id_q;
    assign pc_id       = pc_id_q;
    assign valid_id    = valid_id_q;
    assign halted      = (state_q == ST_HALT);
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the driver steps a behavioural model and
// queues the expected post-edge outputs; the monitor compares on falling edges.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [1:0]  pc_sel;
    logic        stall;
    logic [15:0] branch_target;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] instr_id;
    logic [15:0] pc_id;
    logic        valid_id;
    logic        halted;
    logic [15:0] fetch_count;

    typedef struct {
        int          id;
        logic [15:0] addr;
        logic [15:0] instr;
        logic [15:0] pcid;
        logic        valid;
        logic        halt;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   txn_id = 0;

    // Behavioural model state
    logic [15:0] m_pc, m_instr, m_pcid, m_cnt;
    logic        m_valid, m_halted;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .pc_sel        (pc_sel),
        .stall         (stall),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .instr_id      (instr_id),
        .pc_id         (pc_id),
        .valid_id      (valid_id),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: 0x1111,0x2222,... at the bottom, a jump at 0x10
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] w;
        if (a < 16'h0008)       w = 16'((a / 2 + 1) * 16'h1111);
        else if (a == 16'h0010) w = 16'hC005;
        else                    w = 16'((a * 16'h9E37) ^ 16'h5A5A);
        return w;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic model_reset();
        m_pc = 16'h0000; m_instr = 16'h0000; m_pcid = 16'h0000;
        m_cnt = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
    endtask

    task automatic model_step(input logic [1:0] sel, input logic st, input logic [15:0] bt);
        int off;
        int t;
        if (m_halted) return;
        case (sel)
            2'b00: begin m_instr = 16'h0000; m_valid = 1'b0; m_halted = 1'b1; end
            2'b10: begin
                off = int'(m_instr[11:0]);
                if (off > 2047) off = off - 4096;
                t = int'(m_pcid) + 2 * off;
                m_pc = t[15:0];
                m_instr = 16'h0000; m_valid = 1'b0;
            end
            2'b11: begin m_pc = bt & 16'hFFFE; m_instr = 16'h0000; m_valid = 1'b0; end
            default: begin
                if (!st) begin
                    m_instr = mem_word(m_pc);
                    m_pcid  = m_pc;
                    m_valid = 1'b1;
                    m_pc    = m_pc + 16'd2;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                end
            end
        endcase
    endtask

    task automatic push_expected();
        exp_t e;
        e.id = txn_id; e.addr = m_pc; e.instr = m_instr; e.pcid = m_pcid;
        e.valid = m_valid; e.halt = m_halted; e.cnt = m_cnt;
        exp_q.push_back(e);
        txn_id++;
    endtask

    task automatic do_cycle(input logic [1:0] sel, input logic st, input logic [15:0] bt);
        pc_sel = sel; stall = st; branch_target = bt;
        model_step(sel, st, bt);
        @(posedge clk);
        push_expected();
        @(negedge clk);
    endtask

    // Monitor: compare DUT outputs against the oldest expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (imem_addr !== e.addr || instr_id !== e.instr || pc_id !== e.pcid ||
                valid_id !== e.valid || halted !== e.halt || fetch_count !== e.cnt) begin
                n_bad++;
                $display("FAIL txn %0d: got addr=%h instr=%h pc_id=%h v=%b h=%b cnt=%h, want addr=%h instr=%h pc_id=%h v=%b h=%b cnt=%h",
                         e.id, imem_addr, instr_id, pc_id, valid_id, halted, fetch_count,
                         e.addr, e.instr, e.pcid, e.valid, e.halt, e.cnt);
            end else begin
                $display("ok   txn %0d: addr=%h instr=%h pc_id=%h v=%b h=%b cnt=%h",
                         e.id, imem_addr, instr_id, pc_id, valid_id, halted, fetch_count);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  rsel;
        logic        rst_in;
        logic [15:0] rbt;
        int          r;

        rst = 1'b1; pc_sel = 2'b01; stall = 1'b0; branch_target = 16'h0000;
        model_reset();
        push_expected();              // reset state
        @(negedge clk);
        rst = 1'b0;

        // Sequential fetch from reset: 0,2,4,6
        repeat (2) do_cycle(2'b01, 1'b0, 16'h0000);
        // Stall at pc=4 for two cycles, then resume
        repeat (2) do_cycle(2'b01, 1'b1, 16'h0000);
        repeat (2) do_cycle(2'b01, 1'b0, 16'h0000);
        // Branch to 0x10, fetch the jump word, then take the jump to 0x1A
        do_cycle(2'b11, 1'b0, 16'h0010);
        do_cycle(2'b01, 1'b0, 16'h0000);
        do_cycle(2'b10, 1'b0, 16'h0000);
        do_cycle(2'b01, 1'b0, 16'h0000);
        // Branch together with stall: redirect wins; odd target forced even
        do_cycle(2'b11, 1'b1, 16'h0041);
        do_cycle(2'b01, 1'b0, 16'h0000);
        // PC wrap at the top of the address space
        do_cycle(2'b11, 1'b0, 16'hFFFE);
        repeat (2) do_cycle(2'b01, 1'b0, 16'h0000);
        // Jump with stall asserted
        do_cycle(2'b10, 1'b1, 16'h0000);

        // Randomized running traffic, no halts
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)      rsel = 2'b01;
            else if (r < 8) rsel = 2'b10;
            else            rsel = 2'b11;
            rst_in = ($urandom_range(0, 3) == 0);
            rbt    = 16'($urandom);
            do_cycle(rsel, rst_in, rbt);
        end

        // Halt, then show that nothing moves
        do_cycle(2'b00, 1'b0, 16'h0000);
        repeat (10) do_cycle(2'b01, 1'b0, 16'h0000);
        for (int i = 0; i < 5; i++) do_cycle(2'($urandom), 1'($urandom), 16'($urandom));

        // Reset between edges must take effect immediately
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        push_expected();
        @(negedge clk);
        rst = 1'b0;
        pc_sel = 2'b01; stall = 1'b0;
        repeat (4) do_cycle(2'b01, 1'b0, 16'h0000);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
